add_subb_pipe: RTL and testbench
================================

// Module: add_subb_pipe
// PURPOSE
//   Pipelined, parametrised successor of the add/subtract primitive for the BKM datapath.
//   Computes s = (+/-a) + (+/-b) mod 2^W, plus an exact 2-bit carry.
//   The carry chain is split into STAGES equal chunks, one chunk per clock stage, so W
//   can scale to mantissa widths without a long combinational path.
//   Full throughput: one operation per cycle. Feeds the BKM iteration registers.
// PARAMETERS
//   W       8   operand/result width in bits
//   STAGES  2   pipeline stages = carry-chain chunks; W % STAGES == 0, 1 <= STAGES <= W
//               chunk width CW = W/STAGES
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous reset, active low
//   en         in   1   pipeline advance; 0 = freeze all stage registers
//   in_valid   in   1   input operation valid
//   subb_a     in   1   1 = negate a
//   subb_b     in   1   1 = negate b
//   a          in   W   operand a
//   b          in   W   operand b
//   out_valid  out  1   result valid
//   c          out  2   carry out, range 0..2
//   s          out  W   result
//   v          out  1   signed overflow; present only with ADD_SUBB_PIPE_OVF_EN
// BEHAVIOUR
// - Arithmetic (exact, W+2 bits):
//     {c,s} = a' + b' + subb_a + subb_b,  with a' = subb_a ? ~a : a  and  b' = subb_b ? ~b : b
//   - Therefore s = (+/-a +/- b) mod 2^W.
//   - Both subtract flags set adds 2 at the LSB.
// - Chunk k (0..STAGES-1) is computed in stage k as a (CW+2)-bit sum:
//     a'_k + b'_k + cin_k, where cin_0 = subb_a + subb_b and cin_k = carry out of chunk k-1.
//   - Every inter-chunk carry is 2 bits, range 0..2.
//   - Chunk 0 is computed from the ports directly.
//   - Each stage register holds: finished low chunks, the 2-bit carry, the unconsumed upper
//     chunks of a'/b', the valid bit and (option) the operand sign bits.
// - Latency: STAGES cycles of en=1.
//   - in_valid sampled at edge t with en=1 gives out_valid=1 with the result after edge
//     t+STAGES-1, i.e. visible in the cycle following it.
//   - For STAGES=1 the output is registered once.
// - Throughput: a new operation is accepted on every en=1 cycle.
//   - No backpressure beyond en.
//   - in_valid=0 inserts a bubble; out_valid follows it in order.
// - en=0: every stage register, including the valid bits, holds.
//   - Outputs are stable and inputs are ignored.
// - Invalid slots may carry any data; s/c/v are don't-care when out_valid=0.
// - Reset (rst_n=0 at a rising edge): clears all valid bits, s, c and v to 0 regardless
//   of en.
//   - In-flight operations are discarded; no partial result is ever emitted.
//   - Reset values: out_valid=0, c=2'b00, s=0, v=0.
// - Boundaries:
//   - a=b=0 with both flags set gives {c,s}=2^(W+1) (c=2, s=0).
//   - All-ones + all-ones gives c=1.
//   - Carries of 2 propagate across chunk boundaries unchanged.
// CONFIGURATION
// - `define ADD_SUBB_PIPE_OVF_EN present:
//   - Port v exists and is registered alongside s.
//   - a and b are treated as signed W-bit values; r = (+/-a) + (+/-b) as exact integers.
//   - v=1 iff r lies outside [-2^(W-1), 2^(W-1)-1].
//   - Derived in the last stage from the operand sign bits, the negate flags and the
//     result MSB, which are carried down the pipe.
// - Macro absent: no v port, no sign-bit pipeline registers; all other behaviour identical.
// TESTING (W=8, STAGES=2, en=1 unless stated)
// 1. rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, s=0x00, c=0 throughout.
// 2. a=0x0F, b=0x01, no negate -> 2 cycles later s=0x10, c=0 (chunk-boundary carry).
//    a=0x7F, b=0x01 -> s=0x80, c=0, v=1.
// 3. subb_a=1, a=0x05, b=0x03 -> s=0xFE, c=0, v=0.
//    Both flags, a=0x01, b=0x01 -> s=0xFE, c=1.
// 4. Both flags, a=0x00, b=0x00 -> s=0x00, c=2.
//    No negate, a=0xFF, b=0xFF -> s=0xFE, c=1.
// 5. Three back-to-back ops (0x01+0x01, 0x10+0x20, 0xF0+0x20), en=0 for one cycle
//    mid-stream -> outputs 0x02/0; 0x30/0; 0x10/1 in order, each held while en=0,
//    no duplicates or drops.
// 6. Two ops in flight, rst_n=0 for one edge -> out_valid=0 the next cycle.
//    The in-flight results never appear; the first op after reset completes normally.

Source files
------------

// File: rtl/add_subb_pipe.sv
// add_subb_pipe: pipelined add/subtract primitive for the BKM datapath.
//   Computes {c,s} = (subb_a ? ~a : a) + (subb_b ? ~b : b) + subb_a + subb_b, which gives
//   s = (+/-a +/- b) mod 2^W together with an exact 2-bit carry c in 0..2.
//   The carry chain is cut into STAGES chunks of CW = W/STAGES bits, one chunk per stage.
//   Latency is STAGES cycles of en=1, with full throughput.
// Parameters:
//   W        operand/result width
//   STAGES   pipeline stages / carry-chain chunks (W % STAGES == 0)
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   en         pipeline advance; 0 freezes every stage register
//   in_valid   input operation valid
//   subb_a     negate a
//   subb_b     negate b
//   a, b       operands
//   out_valid  result valid
//   c          carry out (0..2)
//   s          result
//   v          signed overflow (only when ADD_SUBB_PIPE_OVF_EN is defined)
// Optional feature macro: ADD_SUBB_PIPE_OVF_EN adds the v port and the sign-bit pipeline.
module add_subb_pipe #(
  parameter int unsigned W      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic         subb_a,
  input  logic         subb_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [1:0]   c,
  output logic [W-1:0] s
`ifdef ADD_SUBB_PIPE_OVF_EN
  ,
  output logic         v
`endif
);

  localparam int unsigned CW = W / STAGES;

  // Stage inputs: stage 0 reads the ports, stage k reads register k-1.
  logic [W-1:0]  ap_in   [STAGES];
  logic [W-1:0]  bp_in   [STAGES];
  logic [W-1:0]  sum_in  [STAGES];
  logic [1:0]    cin_in  [STAGES];
  logic          vld_in  [STAGES];

  logic [CW+1:0] chunk   [STAGES];
  logic [W-1:0]  sum_d   [STAGES];
  logic [1:0]    carry_d [STAGES];

  // Stage registers: finished low chunks, running carry, operands still to be consumed.
  logic [W-1:0]  ap_q    [STAGES];
  logic [W-1:0]  bp_q    [STAGES];
  logic [W-1:0]  sum_q   [STAGES];
  logic [1:0]    carry_q [STAGES];
  logic          valid_q [STAGES];

`ifdef ADD_SUBB_PIPE_OVF_EN
  // Effective operand signs (sign bit xor negate flag) travel with the data.
  logic          xa_in   [STAGES];
  logic          xb_in   [STAGES];
  logic          xa_q    [STAGES];
  logic          xb_q    [STAGES];
  logic [1:0]    top;
  logic          v_d;
  logic          v_q;
`endif

  always_comb begin
    ap_in[0]  = subb_a ? ~a : a;
    bp_in[0]  = subb_b ? ~b : b;
    sum_in[0] = '0;
    cin_in[0] = {1'b0, subb_a} + {1'b0, subb_b};
    vld_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ap_in[k]  = ap_q[k-1];
      bp_in[k]  = bp_q[k-1];
      sum_in[k] = sum_q[k-1];
      cin_in[k] = carry_q[k-1];
      vld_in[k] = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      // Max value 2*(2^CW-1)+2 = 2^(CW+1), so CW+2 bits hold the sum exactly.
      chunk[k] = {2'b00, ap_in[k][k*CW +: CW]} + {2'b00, bp_in[k][k*CW +: CW]}
               + {{CW{1'b0}}, cin_in[k]};
      sum_d[k] = sum_in[k];
      sum_d[k][k*CW +: CW] = chunk[k][CW-1:0];
      carry_d[k] = chunk[k][CW+1:CW];
    end
  end

`ifdef ADD_SUBB_PIPE_OVF_EN
  always_comb begin
    xa_in[0] = a[W-1] ^ subb_a;
    xb_in[0] = b[W-1] ^ subb_b;
    for (int k = 1; k < STAGES; k++) begin
      xa_in[k] = xa_q[k-1];
      xb_in[k] = xb_q[k-1];
    end
    // Sign-extended operands add {xa,xa} and {xb,xb} above bit W-1, so the exact
    // (W+2)-bit result has top bits c + 3*xa + 3*xb mod 4; overflow when bits
    // W+1, W and W-1 disagree.
    top = carry_d[STAGES-1] + {xa_in[STAGES-1], xa_in[STAGES-1]}
        + {xb_in[STAGES-1], xb_in[STAGES-1]};
    v_d = ~((top[1] == top[0]) && (top[0] == sum_d[STAGES-1][W-1]));
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ap_q[k]    <= '0;
        bp_q[k]    <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= '0;
        valid_q[k] <= 1'b0;
`ifdef ADD_SUBB_PIPE_OVF_EN
        xa_q[k]    <= 1'b0;
        xb_q[k]    <= 1'b0;
`endif
      end
`ifdef ADD_SUBB_PIPE_OVF_EN
      v_q <= 1'b0;
`endif
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        ap_q[k]    <= ap_in[k];
        bp_q[k]    <= bp_in[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        valid_q[k] <= vld_in[k];
`ifdef ADD_SUBB_PIPE_OVF_EN
        xa_q[k]    <= xa_in[k];
        xb_q[k]    <= xb_in[k];
`endif
      end
`ifdef ADD_SUBB_PIPE_OVF_EN
      v_q <= v_d;
`endif
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign c         = carry_q[STAGES-1];
`ifdef ADD_SUBB_PIPE_OVF_EN
  assign v         = v_q;
`endif

endmodule

// File: tb/tb_add_subb_pipe.sv
// tb_add_subb_pipe: directed-vector bench for add_subb_pipe at W=8, STAGES=2.
// Covers reset, chunk-boundary carries, negation, carry-2 corners, en stalls in a
// back-to-back stream and reset with operations in flight.
module tb_add_subb_pipe;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       subb_a;
  logic       subb_b;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic [1:0] c;
  logic [7:0] s;
`ifdef ADD_SUBB_PIPE_OVF_EN
  logic       v;
`endif

  int total = 0;
  int bad   = 0;

  add_subb_pipe #(
    .W      (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .subb_a    (subb_a),
    .subb_b    (subb_b),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c),
    .s         (s)
`ifdef ADD_SUBB_PIPE_OVF_EN
    ,
    .v         (v)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] es, input logic [1:0] ec,
                         input logic ev);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_s"}, {24'd0, s}, {24'd0, es});
    chk({tag, "_c"}, {30'd0, c}, {30'd0, ec});
`ifdef ADD_SUBB_PIPE_OVF_EN
    chk({tag, "_v"}, {31'd0, v}, {31'd0, ev});
`else
    if (ev === 1'bx) $display("note: %s has unknown overflow expectation", tag);
`endif
  endtask

  // Issue one isolated op and check it two edges later.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tsa, input logic tsb, input logic [7:0] es,
                        input logic [1:0] ec, input logic ev);
    a = ta; b = tb; subb_a = tsa; subb_b = tsb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A;
    step();
    chk_out(tag, es, ec, ev);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1;
    subb_a = 1'b0; subb_b = 1'b0; a = 8'h55; b = 8'h33;

    // Reset held two cycles with valid input.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_vld", {31'd0, out_valid}, 32'd0);
      chk("rst_s", {24'd0, s}, 32'd0);
      chk("rst_c", {30'd0, c}, 32'd0);
`ifdef ADD_SUBB_PIPE_OVF_EN
      chk("rst_v", {31'd0, v}, 32'd0);
`endif
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("idle_vld", {31'd0, out_valid}, 32'd0);

    run_op("0f_p_01",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 2'd0, 1'b0);
    run_op("7f_p_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 2'd0, 1'b1);
    run_op("n05_p_03", 8'h05, 8'h03, 1'b1, 1'b0, 8'hFE, 2'd0, 1'b0);
    run_op("n01_n01",  8'h01, 8'h01, 1'b1, 1'b1, 8'hFE, 2'd1, 1'b0);
    run_op("n00_n00",  8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 2'd2, 1'b0);
    run_op("ff_p_ff",  8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 2'd1, 1'b0);
    // 0x10 + ~0x01 + 1 = 0x10F
    run_op("10_n01",   8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 2'd1, 1'b0);
    // -(-128) + 0 = 128 overflows
    run_op("n80_p_00", 8'h80, 8'h00, 1'b1, 1'b0, 8'h80, 2'd0, 1'b1);

    // Back-to-back stream with one stall cycle.
    subb_a = 1'b0; subb_b = 1'b0;
    a = 8'h01; b = 8'h01; in_valid = 1'b1;
    step();
    a = 8'h10; b = 8'h20;
    step();
    chk_out("st1", 8'h02, 2'd0, 1'b0);
    a = 8'hF0; b = 8'h20; en = 1'b0;
    step();
    chk_out("st1_hold", 8'h02, 2'd0, 1'b0);
    en = 1'b1;
    step();
    chk_out("st2", 8'h30, 2'd0, 1'b0);
    in_valid = 1'b0;
    step();
    chk_out("st3", 8'h10, 2'd1, 1'b0);
    step();
    chk("st_end_vld", {31'd0, out_valid}, 32'd0);

    // Reset with two operations in flight.
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    step();
    a = 8'h33; b = 8'h44; rst_n = 1'b0;
    step();
    chk("fl_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("fl_rst_s", {24'd0, s}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("fl_drop1", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl_drop2", {31'd0, out_valid}, 32'd0);
    run_op("fl_after", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
